// File: rtl/pdp8_iot_pkg.sv
// Shared definitions for the PDP-8 IOT bus initiator: phase codes, IOT opcode
// and the sequencer state enum.
package pdp8_iot_pkg;

  localparam logic [3:0] PH_F0 = 4'h0;
  localparam logic [3:0] PH_F1 = 4'h1;
  localparam logic [3:0] PH_F2 = 4'h2;
  localparam logic [3:0] PH_F3 = 4'h3;

  localparam logic [2:0] OPC_IOT = 3'o6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_F3,
    S_FIN
  } iot_state_e;

endpackage

// File: rtl/pdp8_iot_phase_ctr.sv
// Per-phase dwell timer: reloaded at the start of each IOT phase, raises
// last on the final clock of that phase.
module pdp8_iot_phase_ctr #(
  parameter int STATE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic last
);

  localparam logic [3:0] LOAD_VAL = 4'(STATE_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/pdp8_iot_master.sv
// CPU-side IOT bus initiator: sequences F0..F3 on the shared device bus and
// returns the new AC, skip and no-device flags with a one-cycle done pulse.
module pdp8_iot_master
  import pdp8_iot_pkg::*;
#(
  parameter int STATE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] insn,
  input  logic [11:0] ac_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] ac_out,
  output logic        skip,
  output logic        nodev,
  output logic        iot,
  output logic [3:0]  state,
  output logic [11:0] mb,
  output logic [5:0]  io_select,
  output logic [11:0] io_wdata,
  input  logic [11:0] io_rdata,
  input  logic        io_data_avail,
  input  logic        io_selected,
  input  logic        io_skip,
  input  logic        io_interrupt,
  output logic        irq
);

  iot_state_e  st_q, st_d;
  logic [11:0] mb_q, mb_d;
  logic [11:0] wdata_q, wdata_d;
  logic [5:0]  sel_q, sel_d;
  logic [11:0] ac_r_q, ac_r_d;
  logic        skip_r_q, skip_r_d;
  logic        nodev_r_q, nodev_r_d;
  logic [11:0] ac_out_q, ac_out_d;
  logic        skip_q, skip_d;
  logic        nodev_q, nodev_d;
  logic        irq_q;
  logic        ph_load, ph_last;

  pdp8_iot_phase_ctr #(
    .STATE_CYCLES(STATE_CYCLES)
  ) u_phase_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (ph_load),
    .last   (ph_last)
  );

  always_comb begin
    st_d      = st_q;
    mb_d      = mb_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    ac_r_d    = ac_r_q;
    skip_r_d  = skip_r_q;
    nodev_r_d = nodev_r_q;
    ph_load   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          if (insn[11:9] == OPC_IOT) begin
            mb_d    = insn;
            wdata_d = ac_in;
            sel_d   = insn[8:3];
            ph_load = 1'b1;
            st_d    = S_F0;
          end else begin
            // Non-IOT opcodes complete immediately with AC passed through.
            ac_r_d    = ac_in;
            skip_r_d  = 1'b0;
            nodev_r_d = 1'b0;
            st_d      = S_FIN;
          end
        end
      end
      S_F0: begin
        if (ph_last) begin
          ph_load = 1'b1;
          st_d    = S_F1;
        end
      end
      S_F1: begin
        if (ph_last) begin
          skip_r_d  = io_skip;
          nodev_r_d = ~io_selected;
          ph_load   = 1'b1;
          st_d      = S_F2;
        end
      end
      S_F2: begin
        if (ph_last) begin
          ac_r_d  = (io_data_avail && io_selected) ? io_rdata : wdata_q;
          ph_load = 1'b1;
          st_d    = S_F3;
        end
      end
      S_F3: begin
        if (ph_last) begin
          st_d = S_FIN;
        end
      end
      S_FIN: begin
        st_d = S_IDLE;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  // Result registers only change on entry to FIN so they hold between dones.
  always_comb begin
    ac_out_d = ac_out_q;
    skip_d   = skip_q;
    nodev_d  = nodev_q;
    if ((st_d == S_FIN) && (st_q != S_FIN)) begin
      ac_out_d = ac_r_d;
      skip_d   = skip_r_d;
      nodev_d  = nodev_r_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= S_IDLE;
      mb_q      <= 12'd0;
      wdata_q   <= 12'd0;
      sel_q     <= 6'd0;
      ac_r_q    <= 12'd0;
      skip_r_q  <= 1'b0;
      nodev_r_q <= 1'b0;
      ac_out_q  <= 12'd0;
      skip_q    <= 1'b0;
      nodev_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      mb_q      <= mb_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      ac_r_q    <= ac_r_d;
      skip_r_q  <= skip_r_d;
      nodev_r_q <= nodev_r_d;
      ac_out_q  <= ac_out_d;
      skip_q    <= skip_d;
      nodev_q   <= nodev_d;
      irq_q     <= io_interrupt;
    end
  end

  always_comb begin
    busy  = 1'b0;
    state = PH_F0;
    unique case (st_q)
      S_F0:    begin busy = 1'b1; state = PH_F0; end
      S_F1:    begin busy = 1'b1; state = PH_F1; end
      S_F2:    begin busy = 1'b1; state = PH_F2; end
      S_F3:    begin busy = 1'b1; state = PH_F3; end
      default: begin busy = 1'b0; state = PH_F0; end
    endcase
  end

  assign iot       = busy;
  assign done      = (st_q == S_FIN);
  assign ac_out    = ac_out_q;
  assign skip      = skip_q;
  assign nodev     = nodev_q;
  assign mb        = mb_q;
  assign io_select = sel_q;
  assign io_wdata  = wdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_pdp8_iot_master.sv
// Bench for pdp8_iot_master: directed and random IOT transactions on a
// STATE_CYCLES=1 and a STATE_CYCLES=3 instance, checked against a
// per-clock responder schedule model.
module tb_pdp8_iot_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] insn = '0;
  logic [11:0] ac_in = '0;
  logic [11:0] io_rdata = '0;
  logic        io_data_avail = 1'b0;
  logic        io_selected = 1'b0;
  logic        io_skip = 1'b0;
  logic        io_interrupt = 1'b0;
  int          dsel = 0;

  logic st1, st3;
  assign st1 = start && (dsel == 0);
  assign st3 = start && (dsel == 1);

  logic        busy1, done1, skip1, nodev1, iot1, irq1;
  logic [11:0] acout1, mb1, wdata1;
  logic [3:0]  state1;
  logic [5:0]  sel1;
  logic        busy3, done3, skip3, nodev3, iot3, irq3;
  logic [11:0] acout3, mb3, wdata3;
  logic [3:0]  state3;
  logic [5:0]  sel3;

  pdp8_iot_master #(.STATE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(st1), .insn(insn), .ac_in(ac_in),
    .busy(busy1), .done(done1), .ac_out(acout1), .skip(skip1), .nodev(nodev1),
    .iot(iot1), .state(state1), .mb(mb1), .io_select(sel1), .io_wdata(wdata1),
    .io_rdata(io_rdata), .io_data_avail(io_data_avail), .io_selected(io_selected),
    .io_skip(io_skip), .io_interrupt(io_interrupt), .irq(irq1)
  );

  pdp8_iot_master #(.STATE_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(st3), .insn(insn), .ac_in(ac_in),
    .busy(busy3), .done(done3), .ac_out(acout3), .skip(skip3), .nodev(nodev3),
    .iot(iot3), .state(state3), .mb(mb3), .io_select(sel3), .io_wdata(wdata3),
    .io_rdata(io_rdata), .io_data_avail(io_data_avail), .io_selected(io_selected),
    .io_skip(io_skip), .io_interrupt(io_interrupt), .irq(irq3)
  );

  logic        o_busy, o_done, o_skip, o_nodev, o_iot, o_irq;
  logic [11:0] o_acout, o_mb, o_wdata;
  logic [3:0]  o_state;
  logic [5:0]  o_sel;

  always_comb begin
    if (dsel == 0) begin
      o_busy = busy1; o_done = done1; o_skip = skip1; o_nodev = nodev1;
      o_iot = iot1; o_irq = irq1; o_acout = acout1; o_mb = mb1;
      o_wdata = wdata1; o_state = state1; o_sel = sel1;
    end else begin
      o_busy = busy3; o_done = done3; o_skip = skip3; o_nodev = nodev3;
      o_iot = iot3; o_irq = irq3; o_acout = acout3; o_mb = mb3;
      o_wdata = wdata3; o_state = state3; o_sel = sel3;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int iot_cnt = 0;
  int prev_done = -1;
  bit gap_en = 1'b0;
  logic prev_int = 1'b0;

  // Responder schedule, one entry per clock of the F0..F3 window.
  logic        sk_a [16];
  logic        se_a [16];
  logic        av_a [16];
  logic [11:0] rd_a [16];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_iot)  iot_cnt  <= iot_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic sk, input logic se, input logic av, input logic [11:0] rd);
    for (int i = 0; i < 16; i++) begin
      sk_a[i] = sk; se_a[i] = se; av_a[i] = av; rd_a[i] = rd;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      sk_a[i] = 1'($urandom);
      se_a[i] = ($urandom % 4) != 0;
      av_a[i] = 1'($urandom);
      rd_a[i] = 12'($urandom);
    end
  endtask

  // Issues one request from a #1-after-edge point and checks it to completion.
  task automatic txn(input logic [11:0] ti, input logic [11:0] ta, input int pulse_k);
    int n;
    bit is_iot;
    logic [11:0] e_ac;
    logic e_sk, e_nd;
    int dc0, ic0;
    n = (dsel == 0) ? 1 : 3;
    is_iot = (ti[11:9] == 3'o6);
    if (!is_iot) begin
      e_ac = ta; e_sk = 1'b0; e_nd = 1'b0;
    end else begin
      e_sk = sk_a[2*n-1];
      e_nd = !se_a[2*n-1];
      e_ac = (av_a[3*n-1] && se_a[3*n-1]) ? rd_a[3*n-1] : ta;
    end
    dc0 = done_cnt;
    ic0 = iot_cnt;
    insn = ti; ac_in = ta; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    insn = 12'($urandom);
    ac_in = 12'($urandom);
    if (is_iot) begin
      for (int k = 0; k < 4*n; k++) begin
        check_val("bus_iot", o_iot, 1'b1);
        check_val("bus_state", o_state, 4'(k / n));
        check_val("bus_busy", o_busy, 1'b1);
        check_val("bus_done", o_done, 1'b0);
        check_val("bus_mb", o_mb, ti);
        check_val("bus_sel", o_sel, ti[8:3]);
        check_val("bus_wdata", o_wdata, ta);
        check_val("irq", o_irq, prev_int);
        io_interrupt = 1'($urandom);
        prev_int = io_interrupt;
        io_skip = sk_a[k];
        io_selected = se_a[k];
        io_data_avail = av_a[k];
        io_rdata = rd_a[k];
        start = (k == pulse_k);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check_val("fin_done", o_done, 1'b1);
    check_val("fin_busy", o_busy, 1'b0);
    check_val("fin_iot", o_iot, 1'b0);
    check_val("fin_state", o_state, 4'd0);
    check_val("fin_ac", o_acout, e_ac);
    check_val("fin_skip", o_skip, e_sk);
    check_val("fin_nodev", o_nodev, e_nd);
    if (gap_en && prev_done >= 0) check_val("gap", cyc - prev_done, 4*n + 2);
    prev_done = cyc;
    io_skip = 1'b0; io_selected = 1'b0; io_data_avail = 1'b0;
    io_rdata = 12'($urandom);
    @(posedge clk); #1;
    check_val("post_done", o_done, 1'b0);
    check_val("post_ac_hold", o_acout, e_ac);
    check_val("done_count", done_cnt - dc0, 1);
    check_val("iot_clocks", iot_cnt - ic0, is_iot ? 4*n : 0);
  endtask

  initial begin
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    #3;
    check_val("rst_busy1", busy1, 1'b0);
    check_val("rst_done1", done1, 1'b0);
    check_val("rst_iot1", iot1, 1'b0);
    check_val("rst_state1", state1, 4'd0);
    check_val("rst_mb1", mb1, 12'd0);
    check_val("rst_sel1", sel1, 6'd0);
    check_val("rst_wdata1", wdata1, 12'd0);
    check_val("rst_ac1", acout1, 12'd0);
    check_val("rst_flags1", {skip1, nodev1, irq1}, 3'b000);
    check_val("rst_busy3", {busy3, done3, iot3, skip3, nodev3, irq3}, 6'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // STATE_CYCLES = 1 directed cases
    dsel = 0;
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    txn(12'o6046, 12'o0207, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    av_a[2] = 1'b1; rd_a[2] = 12'o0101;
    txn(12'o6036, 12'o5555, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    sk_a[1] = 1'b1;
    txn(12'o6031, 12'o0001, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    sk_a[0] = 1'b1; sk_a[3] = 1'b1;
    txn(12'o6031, 12'o0002, -1);
    txn(12'o7200, 12'o1234, -1);
    fill(1'b0, 1'b0, 1'b1, 12'o7070);
    txn(12'o6036, 12'o0444, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    txn(12'o6046, 12'o0321, 2);

    // Asynchronous reset in the middle of F2
    insn = 12'o6046; ac_in = 12'o0017; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_pre_state", o_state, 4'd2);
    begin
      int dc0;
      dc0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      check_val("rst_mid_iot", o_iot, 1'b0);
      check_val("rst_mid_state", o_state, 4'd0);
      check_val("rst_mid_busy", o_busy, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("rst_no_done", done_cnt - dc0, 0);
      check_val("rst_ac_cleared", o_acout, 12'd0);
      check_val("rst_idle_busy", o_busy, 1'b0);
    end

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      dsel = d;
      prev_done = -1;
      gap_en = 1'b0;
      @(posedge clk); #1;
      for (int t = 0; t < 25; t++) begin
        logic [11:0] ri;
        int pk;
        ri = 12'($urandom);
        if (($urandom % 10) < 7) ri[11:9] = 3'o6;
        else if (ri[11:9] == 3'o6) ri[11:9] = 3'o7;
        pk = (($urandom % 3) == 0) ? int'($urandom % (4 * (d == 0 ? 1 : 3))) : -1;
        fill_rand();
        txn(ri, 12'($urandom), pk);
      end
    end

    // STATE_CYCLES = 3: back-to-back sequences and the skip case
    dsel = 1;
    prev_done = -1;
    gap_en = 1'b1;
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    sk_a[5] = 1'b1;
    sk_a[3] = 1'b0;
    txn(12'o6031, 12'o0100, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    sk_a[0] = 1'b1; sk_a[4] = 1'b1; sk_a[9] = 1'b1; av_a[7] = 1'b1; rd_a[7] = 12'o7777;
    txn(12'o6031, 12'o0200, -1);
    fill(1'b0, 1'b1, 1'b0, 12'd0);
    av_a[8] = 1'b1; rd_a[8] = 12'o0101;
    txn(12'o6036, 12'o0300, -1);
    gap_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
